mem_port_arbiter: RTL

//  Shares the single mainMemory port between the instruction-fetch (I) and data (D) requesters.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single mainMemory port between the I-fetch and D requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise D has fixed priority over I.
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter logic [2:0]  IF_BHW = 3'b100
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr_nrd,
  input  logic [2:0]    d_bhw,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_request,
  output logic [2:0]    mem_bhw,
  output logic          mem_WR_nRD,
  output logic [AW-1:0] mem_ADR,
  output logic [DW-1:0] mem_DATA,
  input  logic [DW-1:0] mem_DATAOUT,
  input  logic          mem_send,
  output logic          busy,
  output logic          grant_d
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t          state, state_nxt;
  logic            pick_d;
  logic            i_ack_nxt, d_ack_nxt, mem_request_nxt, mem_WR_nRD_nxt;
  logic            busy_nxt, grant_d_nxt;
  logic [2:0]      mem_bhw_nxt;
  logic [AW-1:0]   mem_ADR_nxt;
  logic [DW-1:0]   mem_DATA_nxt, i_rdata_nxt, d_rdata_nxt;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D was granted last

  // On a tie the port not granted last wins; a lone requester always wins.
  always_comb begin
    pick_d = d_req && (!i_req || !last_grant);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= 1'b0;
    end else if (state == ST_IDLE && (i_req || d_req)) begin
      last_grant <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_comb begin
    state_nxt       = state;
    i_ack_nxt       = 1'b0;
    d_ack_nxt       = 1'b0;
    mem_request_nxt = 1'b0;
    i_rdata_nxt     = i_rdata;
    d_rdata_nxt     = d_rdata;
    mem_bhw_nxt     = mem_bhw;
    mem_WR_nRD_nxt  = mem_WR_nRD;
    mem_ADR_nxt     = mem_ADR;
    mem_DATA_nxt    = mem_DATA;
    grant_d_nxt     = grant_d;
    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d_nxt     = pick_d;
          mem_request_nxt = 1'b1;
          state_nxt       = ST_ISSUE;
          if (pick_d) begin
            mem_ADR_nxt    = d_adr;
            mem_bhw_nxt    = d_bhw;
            mem_WR_nRD_nxt = d_wr_nrd;
            mem_DATA_nxt   = d_wdata;
          end else begin
            mem_ADR_nxt    = i_adr;
            mem_bhw_nxt    = IF_BHW;
            mem_WR_nRD_nxt = 1'b0;
            mem_DATA_nxt   = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_send) begin
          state_nxt = ST_RESP;
          if (grant_d) begin
            d_rdata_nxt = mem_WR_nRD ? '0 : mem_DATAOUT;
            d_ack_nxt   = 1'b1;
          end else begin
            i_rdata_nxt = mem_DATAOUT;
            i_ack_nxt   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Every output is a flop loaded from its *_nxt value, so the ports stay glitch-free.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_request <= 1'b0;
      mem_bhw     <= '0;
      mem_WR_nRD  <= 1'b0;
      mem_ADR     <= '0;
      mem_DATA    <= '0;
      busy        <= 1'b0;
      grant_d     <= 1'b0;
    end else begin
      state       <= state_nxt;
      i_ack       <= i_ack_nxt;
      d_ack       <= d_ack_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
      mem_request <= mem_request_nxt;
      mem_bhw     <= mem_bhw_nxt;
      mem_WR_nRD  <= mem_WR_nRD_nxt;
      mem_ADR     <= mem_ADR_nxt;
      mem_DATA    <= mem_DATA_nxt;
      busy        <= busy_nxt;
      grant_d     <= grant_d_nxt;
    end
  end

endmodule
